automorph_sched: RTL and testbench
==================================

AUTOMORPH_SCHED -- requirements
Module: automorph_sched

Interface
REQ-001 SHALL have parameter MAX_R, default 31: maximum rotations per FFT iteration.
REQ-002 SHALL have parameter IDX_COUNT, default 256: coefficient indices per rotation, power of two.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10: address width.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: job request, sampled only in IDLE.
REQ-007 SHALL have port num_rot, input, 5: rotations for the job, latched at start, legal range 0..MAX_R.
REQ-008 SHALL have port base_addr, input, ADDR_WIDTH: job base address, latched at start.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse at job completion.
REQ-011 SHALL have port agu_i, output, 32: AGU index input.
REQ-012 SHALL have port agu_r, output, 5: AGU rotation select.
REQ-013 SHALL have port agu_addr, output, ADDR_WIDTH: AGU input address.
REQ-014 SHALL have port agu_out_addr, input, ADDR_WIDTH: AGU registered result, valid exactly 1 cycle after issue.
REQ-015 SHALL have ports out_valid/out_ready, output/input, 1 each: valid/ready handshake to memory.
REQ-016 SHALL have ports out_addr (ADDR_WIDTH), out_r (5) and out_last (1), all outputs: permuted address, its rotation, final-element flag.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-018 SHALL go IDLE->RUN on start with num_rot>=1, IDLE->DONE on start with num_rot==0, and ignore start outside IDLE.
REQ-019 SHALL iterate in RUN with i inner (0..IDX_COUNT-1) and r outer (0..num_rot_q-1), advancing one step per issue.
REQ-020 SHALL drive, on issue, agu_i = zero-extended i, agu_r = r, agu_addr = (base_addr_q + i) mod 2^ADDR_WIDTH, with a tag {r, last} entering a 1-deep in-flight slot.
REQ-021 SHALL hold agu_* stable when not issuing; the AGU result is captured only in the cycle after an issue.
REQ-022 SHALL push each captured result and its tag into a 2-entry output FIFO whose head drives out_addr/out_r/out_last, with out_valid = FIFO non-empty.
REQ-023 SHALL issue only when (FIFO count + in-flight) < 2 (credit rule), so the FIFO never overflows under any out_ready pattern.
REQ-024 SHALL pop the FIFO on out_valid && out_ready; push and pop in the same cycle keep the count unchanged.
REQ-025 SHALL hold out_addr/out_r/out_last stable while out_valid && !out_ready.
REQ-026 SHALL set the last tag only on (i==IDX_COUNT-1, r==num_rot_q-1).
REQ-027 SHALL go RUN->DRAIN in the cycle after the last issue.
REQ-028 SHALL go DRAIN->DONE when the FIFO is empty and nothing is in flight.
REQ-029 SHALL pulse done for exactly the one DONE cycle, then go to IDLE.
REQ-030 SHALL clamp num_rot>MAX_R to MAX_R at latch.
REQ-031 SHALL accept a new start one cycle after done, giving back-to-back jobs.

Reset
REQ-032 SHALL, on rst, force state IDLE, all counters 0, FIFO empty, in-flight clear, busy=0, done=0, out_valid=0, and agu_i/agu_r/agu_addr/out_addr/out_r/out_last=0.
REQ-033 SHALL abort a job on reset asserted mid-job, with no done pulse and no further out_valid until a new start.

Structure
REQ-034 SHALL place MAX_R, the state enum and the tag struct {r, last} in shared package automorph_pkg.
REQ-035 SHALL implement the 2-entry output FIFO as sub-module automorph_sched_fifo; the scheduler instantiates but does not contain the AGU.

Verification
REQ-036 SHALL cover: IDX_COUNT=4, num_rot=2, base_addr=0x10, out_ready=1 -> 8 outputs, r sequence 0,0,0,0,1,1,1,1; out_last only on the 8th output; done 1 cycle after DRAIN empties.
REQ-037 SHALL cover: same job with out_ready=0 for 10 cycles -> exactly 2 issues, out_valid held with stable out_addr, no loss or duplication after release.
REQ-038 SHALL cover: start with num_rot=0 -> DONE next cycle, done pulse, zero out_valid cycles.
REQ-039 SHALL cover: rst asserted at output 3 of 8 -> all outputs 0 next cycle, no done pulse, clean rerun after a new start.
REQ-040 SHALL cover: base_addr=0x3FE, IDX_COUNT=4 -> agu_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-041 SHALL cover: random out_ready at 50% over num_rot=31 -> 31*IDX_COUNT outputs in order, matching a reference model of the AGU.

Source files
------------

// File: rtl/automorph_pkg.sv
// rtl/automorph_pkg.sv - shared types and limits for the automorphism scheduler
package automorph_pkg;

  localparam int MAX_R = 31;
  localparam int ROT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ROT_W-1:0] r;
    logic             last;
  } tag_t;

endpackage

// File: rtl/automorph_sched_fifo.sv
// rtl/automorph_sched_fifo.sv - 2-entry output FIFO holding permuted address and tag
module automorph_sched_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // Storage is cleared on reset so the head reads zero while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/automorph_sched.sv
// rtl/automorph_sched.sv - issues (i, r) steps to an external AGU and streams permuted addresses
module automorph_sched #(
  parameter int MAX_R      = automorph_pkg::MAX_R,
  parameter int IDX_COUNT  = 256,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            num_rot,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           agu_i,
  output logic [4:0]            agu_r,
  output logic [ADDR_WIDTH-1:0] agu_addr,
  input  logic [ADDR_WIDTH-1:0] agu_out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [4:0]            out_r,
  output logic                  out_last
);
  import automorph_pkg::*;

  localparam int IW = (IDX_COUNT > 1) ? $clog2(IDX_COUNT) : 1;
  localparam int FW = ADDR_WIDTH + $bits(tag_t);

  state_t                state, state_nxt;
  logic [IW-1:0]         i_q;
  logic [4:0]            r_q;
  logic [4:0]            num_rot_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  inflight_q;
  tag_t                  inflight_tag_q;
  tag_t                  issue_tag;
  logic                  issue;
  logic                  last_step;
  logic                  pop;
  logic [4:0]            num_rot_clamped;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic [FW-1:0]         fifo_head;

  assign num_rot_clamped = (num_rot > 5'(MAX_R)) ? 5'(MAX_R) : num_rot;
  assign last_step       = (i_q == IW'(IDX_COUNT - 1)) && (r_q == num_rot_q - 5'd1);
  // Credit: a slot is reserved for the in-flight AGU result before it arrives.
  assign issue           = (state == S_RUN) &&
                           (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);
  assign issue_tag       = '{r: r_q, last: last_step};
  assign pop             = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_rot == 5'd0) ? S_DONE : S_RUN;
      S_RUN:   if (issue && last_step) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty && !inflight_q) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      i_q            <= '0;
      r_q            <= 5'd0;
      num_rot_q      <= 5'd0;
      base_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
    end else begin
      state      <= state_nxt;
      inflight_q <= issue;
      if (issue) inflight_tag_q <= issue_tag;
      if (state == S_IDLE && start) begin
        num_rot_q <= num_rot_clamped;
        base_q    <= base_addr;
        i_q       <= '0;
        r_q       <= 5'd0;
      end else if (issue) begin
        if (last_step) begin
          i_q <= '0;
          r_q <= 5'd0;
        end else if (i_q == IW'(IDX_COUNT - 1)) begin
          i_q <= '0;
          r_q <= r_q + 5'd1;
        end else begin
          i_q <= i_q + 1'b1;
        end
      end
    end
  end

  // AGU inputs come straight from the counters, which only move on issue.
  assign agu_i    = 32'(i_q);
  assign agu_r    = r_q;
  assign agu_addr = base_q + ADDR_WIDTH'(i_q);

  automorph_sched_fifo #(.W(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({agu_out_addr, inflight_tag_q}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign {out_addr, out_r, out_last} = fifo_head;
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_automorph_sched.sv
// tb/tb_automorph_sched.sv - directed vector bench for automorph_sched
module tb_automorph_sched;

  localparam int IDX    = 4;
  localparam int AW     = 10;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4:0]    num_rot;
  logic [AW-1:0] base_addr;
  logic          busy, done;
  logic [31:0]   agu_i;
  logic [4:0]    agu_r;
  logic [AW-1:0] agu_addr;
  logic [AW-1:0] agu_out_addr;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_addr;
  logic [4:0]    out_r;
  logic          out_last;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  automorph_sched #(.MAX_R(31), .IDX_COUNT(IDX), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rot(num_rot), .base_addr(base_addr),
    .busy(busy), .done(done), .agu_i(agu_i), .agu_r(agu_r), .agu_addr(agu_addr),
    .agu_out_addr(agu_out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_r(out_r), .out_last(out_last)
  );

  // Reference AGU: registered, one-cycle latency.
  always_ff @(posedge clk) agu_out_addr <= agu_addr + 10'(agu_r) * 10'd3;

  typedef struct {
    logic [4:0]    num_rot;
    logic [AW-1:0] base;
    int            mode;     // 0 ready always, 1 random, 2 stalled first 10 cycles
    int            exp_outs;
  } job_t;

  job_t jobs [6];

  function automatic int exp_addr(input int base, input int k);
    int r = k / IDX;
    int i = k % IDX;
    return (base + i + r * 3) & ((1 << AW) - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input job_t j);
    int got = 0;
    int last_xfer = -1;
    int done_at = -1;
    int done_cnt = 0;
    int late_valid = 0;
    @(negedge clk);
    start = 1'b1; num_rot = j.num_rot; base_addr = j.base; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      case (j.mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc >= 10);
      endcase
      if (cyc == 0) chk("busy_after_start", int'(busy), 1);
      if (j.mode == 2 && cyc == 9) begin
        chk("stall_issue_count", int'(agu_i), 2);
        chk("stall_valid_held", int'(out_valid), 1);
        chk("stall_addr_stable", int'(out_addr), exp_addr(j.base, 0));
      end
      if (done_at >= 0 && out_valid) late_valid++;
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (out_valid && out_ready) begin
        chk("out_addr", int'(out_addr), exp_addr(j.base, got));
        chk("out_r", int'(out_r), got / IDX);
        chk("out_last", int'(out_last), int'(got == j.exp_outs - 1));
        got++;
        last_xfer = cyc;
      end
      @(negedge clk);
      if (done_at >= 0 && cyc >= done_at + 3) break;
    end
    chk("output_count", got, j.exp_outs);
    chk("done_pulses", done_cnt, 1);
    chk("valid_after_done", late_valid, 0);
    if (j.exp_outs > 0) chk("done_timing", done_at, last_xfer + 2);
    else                chk("done_timing_zero", done_at, 0);
  endtask

  initial begin
    int got;
    int bad;
    jobs[0] = '{num_rot: 5'd2,  base: 10'h010, mode: 0, exp_outs: 8};
    jobs[1] = '{num_rot: 5'd1,  base: 10'h3FE, mode: 0, exp_outs: 4};
    jobs[2] = '{num_rot: 5'd0,  base: 10'h055, mode: 0, exp_outs: 0};
    jobs[3] = '{num_rot: 5'd2,  base: 10'h010, mode: 2, exp_outs: 8};
    jobs[4] = '{num_rot: 5'd3,  base: 10'h100, mode: 1, exp_outs: 12};
    jobs[5] = '{num_rot: 5'd31, base: 10'h200, mode: 1, exp_outs: 124};

    rst = 1'b1; start = 1'b0; num_rot = 5'd0; base_addr = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_agu", int'(agu_i) + int'(agu_r) + int'(agu_addr), 0);
    chk("rst_out", int'(out_addr) + int'(out_r) + int'(out_last), 0);

    for (int n = 0; n < 6; n++) run_job(jobs[n]);

    // Reset in the middle of a job, after the third output.
    @(negedge clk);
    start = 1'b1; num_rot = 5'd2; base_addr = 10'h010; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 50 && got < 3; cyc++) begin
      if (out_valid) got++;
      if (got == 3) rst = 1'b1;
      else @(negedge clk);
    end
    chk("mid_reset_reached", got, 3);
    @(negedge clk);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out", int'(out_addr) + int'(out_r) + int'(out_last), 0);
    chk("mid_rst_agu", int'(agu_i) + int'(agu_r) + int'(agu_addr), 0);
    rst = 1'b0;
    bad = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (out_valid || done || busy) bad++;
    end
    chk("quiet_after_abort", bad, 0);
    run_job(jobs[0]);

    // Back-to-back zero-rotation jobs; start is ignored while in DONE.
    @(negedge clk);
    start = 1'b1; num_rot = 5'd0;
    @(negedge clk);
    chk("b2b_done1", int'(done), 1);
    @(negedge clk);
    chk("b2b_ignored_in_done", int'(done), 0);
    chk("b2b_idle", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done2", int'(done), 1);
    @(negedge clk);
    chk("b2b_end", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
